// File: rtl/afu_irq_pkg.sv
// Shared types, default sizing and index-decode helpers for the AFU interrupt arbiter.
package afu_irq_pkg;

  localparam int unsigned NUM_AFUS_DEF  = 1;
  localparam int unsigned NUM_VEC_DEF   = 7;
  localparam int unsigned LNUM_AFUS_DEF = 1;
  localparam int unsigned L_NUM_VEC_DEF = 3;

  localparam int unsigned NUM_SRC = NUM_AFUS_DEF * NUM_VEC_DEF;
  localparam int unsigned SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } t_irq_arb_state;

  // Flat source index -> AFU index; only evaluated at elaboration to build lookup tables.
  function automatic int unsigned src2afu(input int unsigned src, input int unsigned nvec);
    return src / nvec;
  endfunction

  function automatic int unsigned src2vec(input int unsigned src, input int unsigned nvec);
    return src % nvec;
  endfunction

endpackage

// File: rtl/fim_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping at N.
module fim_rr_arb #(
  parameter int unsigned N = 7,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);

  always_comb begin
    int unsigned idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!gnt_vld && req[W'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_idx = W'(idx);
      end
    end
  end

endmodule

// File: rtl/afu_irq_arb.sv
// Shares the MSI-X issue channel among all AFU interrupt vectors: pending latch,
// mask filtering, round-robin grant, valid/ready issue and per-vector ack pulse.
module afu_irq_arb
  import afu_irq_pkg::*;
#(
  parameter int unsigned NUM_AFUS  = NUM_AFUS_DEF,
  parameter int unsigned NUM_VEC   = NUM_VEC_DEF,
  parameter int unsigned LNUM_AFUS = LNUM_AFUS_DEF,
  parameter int unsigned L_NUM_VEC = L_NUM_VEC_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_AFUS*NUM_VEC-1:0]  afu_irq_req,
  input  logic [NUM_AFUS*NUM_VEC-1:0]  vec_mask,
  output logic                         irq_valid,
  input  logic                         irq_ready,
  output logic [LNUM_AFUS-1:0]         irq_afu,
  output logic [L_NUM_VEC-1:0]         irq_vec,
  output logic [NUM_AFUS*NUM_VEC-1:0]  afu_irq_ack,
  output logic [NUM_AFUS*NUM_VEC-1:0]  pba,
  output logic [CNT_W-1:0]             coalesce_cnt
);

  localparam int unsigned N_SRC = NUM_AFUS * NUM_VEC;
  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  t_irq_arb_state       state_q, state_d;
  logic [N_SRC-1:0]     pend_q, pend_d;
  logic [N_SRC-1:0]     ack_q, ack_d;
  logic                 valid_q, valid_d;
  logic [LNUM_AFUS-1:0] afu_q, afu_d;
  logic [L_NUM_VEC-1:0] vec_q, vec_d;
  logic [IDX_W-1:0]     sel_q, sel_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [N_SRC-1:0]     elig;
  logic [N_SRC-1:0]     clr;
  logic [N_SRC-1:0]     coal_hit;
  logic [SUM_W-1:0]     cnt_sum;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_vld;

  // Constant-divisor decode of flat source index into AFU / vector fields.
  logic [LNUM_AFUS-1:0] afu_lut [N_SRC];
  logic [L_NUM_VEC-1:0] vec_lut [N_SRC];

  for (genvar g = 0; g < N_SRC; g++) begin : g_lut
    assign afu_lut[g] = LNUM_AFUS'(src2afu(g, NUM_VEC));
    assign vec_lut[g] = L_NUM_VEC'(src2vec(g, NUM_VEC));
  end

  assign elig = pend_q & ~vec_mask;

  fim_rr_arb #(
    .N (N_SRC),
    .W (IDX_W)
  ) u_rr_arb (
    .req     (elig),
    .ptr     (rr_q),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    afu_d    = afu_q;
    vec_d    = vec_q;
    sel_d    = sel_q;
    rr_d     = rr_q;
    ack_d    = '0;
    clr      = '0;
    pend_d   = pend_q;
    coal_hit = '0;
    cnt_sum  = '0;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          sel_d   = gnt_idx;
          afu_d   = afu_lut[gnt_idx];
          vec_d   = vec_lut[gnt_idx];
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // No retraction: only the handshake ends an issue.
        if (irq_ready) begin
          clr[sel_q]   = 1'b1;
          ack_d[sel_q] = 1'b1;
          rr_d         = (sel_q == IDX_W'(N_SRC - 1)) ? '0 : sel_q + 1'b1;
          valid_d      = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new request on the vector being cleared wins and is not a coalesce.
    pend_d   = (pend_q & ~clr) | afu_irq_req;
    coal_hit = afu_irq_req & pend_q & ~clr;
    cnt_sum  = SUM_W'(cnt_q) + SUM_W'($countones(coal_hit));
    cnt_d    = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ack_q   <= '0;
      valid_q <= 1'b0;
      afu_q   <= '0;
      vec_q   <= '0;
      sel_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      afu_q   <= afu_d;
      vec_q   <= vec_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign irq_valid    = valid_q;
  assign irq_afu      = afu_q;
  assign irq_vec      = vec_q;
  assign afu_irq_ack  = ack_q;
  assign pba          = pend_q;
  assign coalesce_cnt = cnt_q;

endmodule

// File: tb/tb_afu_irq_arb.sv
// Scoreboard bench for afu_irq_arb: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of pending/grant/ack rules.
module tb_afu_irq_arb;

  localparam int unsigned NS = 7;
  localparam int unsigned NV = 7;
  localparam int unsigned CW = 16;
  localparam int CMAX = 65535;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] afu_irq_req;
  logic [NS-1:0] vec_mask;
  logic          irq_valid;
  logic          irq_ready;
  logic [0:0]    irq_afu;
  logic [2:0]    irq_vec;
  logic [NS-1:0] afu_irq_ack;
  logic [NS-1:0] pba;
  logic [CW-1:0] coalesce_cnt;

  always #5 clk = ~clk;

  afu_irq_arb dut (
    .clk          (clk),
    .rst          (rst),
    .afu_irq_req  (afu_irq_req),
    .vec_mask     (vec_mask),
    .irq_valid    (irq_valid),
    .irq_ready    (irq_ready),
    .irq_afu      (irq_afu),
    .irq_vec      (irq_vec),
    .afu_irq_ack  (afu_irq_ack),
    .pba          (pba),
    .coalesce_cnt (coalesce_cnt)
  );

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // Reference model state
  bit [NS-1:0] m_pend;
  bit [NS-1:0] m_ack;
  bit          m_busy;
  int          m_sel;
  int          m_rr;
  int          m_cnt;
  int          gq[$];    // expected grants (flat index), oldest first
  int          seen[$];  // handshakes observed on the DUT

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: evaluated on each clock edge from the inputs in force.
  always @(posedge clk) begin : model
    int clr;
    int idx;
    bit [NS-1:0] old;
    if (rst) begin
      m_pend = '0;
      m_ack  = '0;
      m_busy = 1'b0;
      m_sel  = 0;
      m_rr   = 0;
      m_cnt  = 0;
      gq.delete();
    end else begin
      clr   = -1;
      old   = m_pend;
      m_ack = '0;
      if (m_busy) begin
        if (irq_ready) begin
          m_ack[m_sel] = 1'b1;
          clr          = m_sel;
          m_rr         = (m_sel + 1) % NS;
          m_busy       = 1'b0;
        end
      end else begin
        for (int k = 0; k < NS; k++) begin
          idx = (m_rr + k) % NS;
          if (!m_busy && old[idx] && !vec_mask[idx]) begin
            m_busy = 1'b1;
            m_sel  = idx;
            gq.push_back(idx);
          end
        end
      end
      for (int i = 0; i < NS; i++) begin
        if (afu_irq_req[i]) begin
          if (old[i] && i != clr) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
          m_pend[i] = 1'b1;
        end else if (i == clr) begin
          m_pend[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model away from the clock edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid", 64'(irq_valid), 64'(m_busy));
      chk("pba", 64'(pba), 64'(m_pend));
      chk("coalesce_cnt", 64'(coalesce_cnt), 64'(m_cnt));
      chk("ack", 64'(afu_irq_ack), 64'(m_ack));
      if (irq_valid === 1'b1) begin
        if (gq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL grant_unexpected: got afu=%0d vec=%0d expected no grant at %0t",
                   irq_afu, irq_vec, $time);
        end else begin
          chk("irq_afu", 64'(irq_afu), 64'(gq[0] / NV));
          chk("irq_vec", 64'(irq_vec), 64'(gq[0] % NV));
          if (irq_ready === 1'b1) begin
            seen.push_back(int'(irq_afu) * NV + int'(irq_vec));
            void'(gq.pop_front());
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    seen.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NS-1:0] r;
    logic [NS-1:0] m;
    bit found;

    rst         = 1'b1;
    afu_irq_req = '0;
    vec_mask    = '0;
    irq_ready   = 1'b0;
    repeat (3) step();
    mon_en = 1'b1;
    chk("rst_valid", 64'(irq_valid), 64'd0);
    chk("rst_pba", 64'(pba), 64'd0);
    chk("rst_cnt", 64'(coalesce_cnt), 64'd0);
    chk("rst_ack", 64'(afu_irq_ack), 64'd0);
    rst = 1'b0;

    // Single request with ready held high
    irq_ready   = 1'b1;
    afu_irq_req = 7'h08;
    step();
    afu_irq_req = '0;
    chk("t1_pba_set", 64'(pba), 64'h08);
    chk("t1_valid_early", 64'(irq_valid), 64'd0);
    step();
    chk("t1_valid", 64'(irq_valid), 64'd1);
    chk("t1_vec", 64'(irq_vec), 64'd3);
    chk("t1_afu", 64'(irq_afu), 64'd0);
    step();
    chk("t1_ack", 64'(afu_irq_ack), 64'h08);
    chk("t1_pba_clr", 64'(pba), 64'd0);
    chk("t1_valid_drop", 64'(irq_valid), 64'd0);
    step();
    chk("t1_ack_once", 64'(afu_irq_ack), 64'd0);

    // Masked vector stays pending until unmasked
    do_reset();
    irq_ready   = 1'b0;
    vec_mask    = 7'h04;
    afu_irq_req = 7'h04;
    step();
    afu_irq_req = '0;
    for (int c = 0; c < 50; c++) begin
      step();
      chk("t2_masked_valid", 64'(irq_valid), 64'd0);
    end
    chk("t2_pba", 64'(pba), 64'h04);
    vec_mask = '0;
    step();
    chk("t2_unmask_valid", 64'(irq_valid), 64'd1);
    chk("t2_unmask_vec", 64'(irq_vec), 64'd2);
    irq_ready = 1'b1;
    step();
    step();

    // Round-robin ordering with re-requests during a grant
    do_reset();
    irq_ready   = 1'b1;
    afu_irq_req = 7'h23;
    step();
    afu_irq_req = '0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (irq_valid === 1'b1 && irq_vec == 3'd1) found = 1'b1;
      else step();
    end
    chk("t3_found_vec1", 64'(found), 64'd1);
    afu_irq_req = 7'h21;
    step();
    afu_irq_req = '0;
    for (int c = 0; c < 30 && seen.size() < 4; c++) step();
    chk("t3_count", 64'(seen.size()), 64'd4);
    if (seen.size() >= 4) begin
      chk("t3_g0", 64'(seen[0]), 64'd0);
      chk("t3_g1", 64'(seen[1]), 64'd1);
      chk("t3_g2", 64'(seen[2]), 64'd5);
      chk("t3_g3", 64'(seen[3]), 64'd0);
    end

    // Backpressure with coalesced requests
    do_reset();
    irq_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      afu_irq_req = 7'h10;
      step();
      afu_irq_req = '0;
      repeat (9) step();
    end
    chk("t4_cnt", 64'(coalesce_cnt), 64'd2);
    chk("t4_valid", 64'(irq_valid), 64'd1);
    chk("t4_vec", 64'(irq_vec), 64'd4);
    irq_ready = 1'b1;
    step();
    chk("t4_ack", 64'(afu_irq_ack), 64'h10);
    chk("t4_pba", 64'(pba), 64'd0);
    repeat (4) step();
    chk("t4_one_grant", 64'(seen.size()), 64'd1);

    // Set wins over clear at the handshake
    do_reset();
    irq_ready   = 1'b0;
    afu_irq_req = 7'h10;
    step();
    afu_irq_req = '0;
    step();
    chk("t5_valid", 64'(irq_valid), 64'd1);
    irq_ready   = 1'b1;
    afu_irq_req = 7'h10;
    step();
    afu_irq_req = '0;
    chk("t5_pba_kept", 64'(pba), 64'h10);
    chk("t5_cnt", 64'(coalesce_cnt), 64'd0);
    chk("t5_ack", 64'(afu_irq_ack), 64'h10);
    step();
    chk("t5_regrant_valid", 64'(irq_valid), 64'd1);
    chk("t5_regrant_vec", 64'(irq_vec), 64'd4);
    step();
    chk("t5_ack2", 64'(afu_irq_ack), 64'h10);
    chk("t5_pba_clr", 64'(pba), 64'd0);

    // Reset while an interrupt is being issued
    do_reset();
    irq_ready   = 1'b0;
    afu_irq_req = 7'h02;
    step();
    afu_irq_req = '0;
    step();
    afu_irq_req = 7'h02;
    step();
    afu_irq_req = '0;
    chk("t6_valid", 64'(irq_valid), 64'd1);
    chk("t6_cnt", 64'(coalesce_cnt), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_valid", 64'(irq_valid), 64'd0);
    chk("t6_rst_pba", 64'(pba), 64'd0);
    chk("t6_rst_cnt", 64'(coalesce_cnt), 64'd0);
    chk("t6_rst_ack", 64'(afu_irq_ack), 64'd0);
    step();
    chk("t6_no_ack", 64'(afu_irq_ack), 64'd0);

    // Randomized traffic, masks, backpressure and occasional reset
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r = '0;
      for (int b = 0; b < NS; b++) if ($urandom_range(0, 9) == 0) r[b] = 1'b1;
      afu_irq_req = r;
      if ($urandom_range(0, 29) == 0) begin
        m = '0;
        for (int b = 0; b < NS; b++) if ($urandom_range(0, 3) == 0) m[b] = 1'b1;
        vec_mask = m;
      end
      irq_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 599) == 0);
      step();
    end
    afu_irq_req = '0;
    vec_mask    = '0;
    rst         = 1'b0;
    irq_ready   = 1'b1;
    repeat (40) step();
    chk("drain_pba", 64'(pba), 64'd0);
    chk("drain_gq", 64'(gq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
